// File: rtl/nes_palette_ram.sv
// -----------------------------------------------------------------------------
// nes_palette_ram
//
// Writable NES PPU palette memory. After reset (or on init_req) the whole
// palette is copied from an external clocked palette ROM. Once loaded, the
// memory serves a CPU read/write port (the $2007 path) and a render read port
// feeding the colour->RGB LUT. The PPU $3F1x mirroring rule can be applied to
// both ports, and the render port has a greyscale mode.
//
// Ports:
//   clk        : clock, all logic on posedge
//   rst        : asynchronous active-high reset
//   init_req   : pulse, reload whole palette from ROM (honoured only in RUN)
//   init_done  : 1 = RUN (ports serviced), 0 = loading
//   ld_addr    : address to the external palette ROM
//   ld_data    : ROM data, valid one clock after ld_addr
//   cpu_we     : CPU write strobe
//   cpu_addr   : CPU read/write address
//   cpu_wdata  : CPU write data
//   cpu_rdata  : CPU read data, 1 clock latency, read-before-write
//   rd_addr    : render read address
//   grey       : greyscale, keep only the two top bits of the render data
//   rd_data    : render read data, 1 clock latency
// -----------------------------------------------------------------------------
module nes_palette_ram #(
  parameter int DATA_W    = 6,
  parameter int ADDR_W    = 5,
  parameter int MIRROR_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_req,
  output logic              init_done,
  output logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              grey,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [0:0] ST_LOAD = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [ADDR_W:0]   CNT_FULL  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0]   CNT_ZERO  = '0;
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_ZERO = '0;
  localparam logic [ADDR_W-1:0] MIR_SEL   = ADDR_W'(5'h13);
  localparam logic [ADDR_W-1:0] MIR_HIT   = ADDR_W'(5'h10);
  localparam logic [DATA_W-1:0] GREY_MASK = {2'b11, {(DATA_W - 2){1'b0}}};
  localparam logic [DATA_W-1:0] DATA_ZERO = '0;

  // $3F10/$3F14/$3F18/$3F1C share storage with $3F00/$3F04/$3F08/$3F0C:
  // bit 4 set and bits [1:0] clear selects an alias of the lower entry.
  function automatic logic [ADDR_W-1:0] mirror_addr(input logic [ADDR_W-1:0] a);
    if ((MIRROR_EN != 0) && ((a & MIR_SEL) == MIR_HIT)) begin
      return a & ~MIR_HIT;
    end else begin
      return a;
    end
  endfunction

  logic [0:0]        state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;          // load counter, saturates at DEPTH
  logic              vld_q, vld_d;          // ROM data for ld_addr_q arrives this clk
  logic [ADDR_W-1:0] ld_addr_q, ld_addr_d;  // ld_addr delayed one clk (ROM latency)
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_waddr_s;
  logic [DATA_W-1:0] mem_wdata_s;
  logic [ADDR_W-1:0] cpu_map_s;
  logic [ADDR_W-1:0] rd_map_s;
  logic [DATA_W-1:0] rd_word_s;

  assign cpu_map_s = mirror_addr(cpu_addr);
  assign rd_map_s  = mirror_addr(rd_addr);
  assign rd_word_s = mem_q[rd_map_s];

  // Next-state, load sequencing and port logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    vld_d       = 1'b0;
    ld_addr_d   = cnt_q[ADDR_W-1:0];
    cpu_rdata_d = cpu_rdata_q;
    rd_data_d   = DATA_ZERO;
    mem_we_s    = 1'b0;
    mem_waddr_s = ADDR_ZERO;
    mem_wdata_s = DATA_ZERO;

    case (state_q)
      ST_LOAD: begin
        // An address is issued only while the counter is below DEPTH; the
        // matching ROM word is written one clk later at the delayed address.
        if (cnt_q < CNT_FULL) begin
          vld_d = 1'b1;
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          vld_d = 1'b0;
          cnt_d = cnt_q;
        end
        if (vld_q) begin
          mem_we_s    = 1'b1;
          mem_waddr_s = ld_addr_q;
          mem_wdata_s = ld_data;
          if (ld_addr_q == ADDR_LAST) begin
            state_d = ST_RUN;
            cnt_d   = CNT_ZERO;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          mem_we_s = 1'b0;
        end
      end
      ST_RUN: begin
        // Reads see the pre-write contents because mem_q updates at the edge.
        cpu_rdata_d = mem_q[cpu_map_s];
        if (grey) begin
          rd_data_d = rd_word_s & GREY_MASK;
        end else begin
          rd_data_d = rd_word_s;
        end
        if (cpu_we) begin
          mem_we_s    = 1'b1;
          mem_waddr_s = cpu_map_s;
          mem_wdata_s = cpu_wdata;
        end else begin
          mem_we_s = 1'b0;
        end
        cnt_d = CNT_ZERO;
        if (init_req) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_LOAD;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Control and output registers, asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_LOAD;
      cnt_q       <= CNT_ZERO;
      vld_q       <= 1'b0;
      ld_addr_q   <= ADDR_ZERO;
      cpu_rdata_q <= DATA_ZERO;
      rd_data_q   <= DATA_ZERO;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      vld_q       <= vld_d;
      ld_addr_q   <= ld_addr_d;
      cpu_rdata_q <= cpu_rdata_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // Palette storage; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[mem_waddr_s] <= mem_wdata_s;
    end
  end

  // Counter low bits are zero both in RUN and once saturated at DEPTH.
  assign ld_addr   = cnt_q[ADDR_W-1:0];
  assign init_done = (state_q == ST_RUN);
  assign cpu_rdata = cpu_rdata_q;
  assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_nes_palette_ram.sv
// -----------------------------------------------------------------------------
// tb_nes_palette_ram
//
// Directed bench for nes_palette_ram. Two instances share all inputs: dut_a
// with mirroring enabled, dut_b with mirroring disabled. Each has its own
// clocked ROM model returning addr ^ 6'h15. Expected read data is computed
// from per-instance reference memories, pushed to a scoreboard queue when a
// read is driven and popped when the DUT output is sampled.
// -----------------------------------------------------------------------------
module tb_nes_palette_ram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       init_req;
  logic       cpu_we;
  logic [4:0] cpu_addr;
  logic [5:0] cpu_wdata;
  logic [4:0] rd_addr;
  logic       grey;

  logic       init_done_a, init_done_b;
  logic [4:0] ld_addr_a, ld_addr_b;
  logic [5:0] ld_data_a, ld_data_b;
  logic [5:0] cpu_rdata_a, cpu_rdata_b;
  logic [5:0] rd_data_a, rd_data_b;

  nes_palette_ram #(.DATA_W(6), .ADDR_W(5), .MIRROR_EN(1)) dut_a (
    .clk(clk), .rst(rst), .init_req(init_req), .init_done(init_done_a),
    .ld_addr(ld_addr_a), .ld_data(ld_data_a), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata_a),
    .rd_addr(rd_addr), .grey(grey), .rd_data(rd_data_a)
  );

  nes_palette_ram #(.DATA_W(6), .ADDR_W(5), .MIRROR_EN(0)) dut_b (
    .clk(clk), .rst(rst), .init_req(init_req), .init_done(init_done_b),
    .ld_addr(ld_addr_b), .ld_data(ld_data_b), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata_b),
    .rd_addr(rd_addr), .grey(grey), .rd_data(rd_data_b)
  );

  // Clocked palette ROMs, one clk of latency.
  always @(posedge clk) begin
    ld_data_a <= 6'({1'b0, ld_addr_a}) ^ 6'h15;
    ld_data_b <= 6'({1'b0, ld_addr_b}) ^ 6'h15;
  end

  typedef struct {
    string      tag;
    logic [1:0] sel;   // 0 rd_a, 1 rd_b, 2 cpu_a, 3 cpu_b
    logic [5:0] exp;
  } item_t;

  item_t      sb[$];
  logic [5:0] mem_a [32];
  logic [5:0] mem_b [32];
  int         checks = 0;
  int         errors = 0;

  function automatic logic [4:0] map_addr(input logic [4:0] a, input bit en);
    if (en && a[4] && (a[1:0] == 2'b00)) return {1'b0, a[3:0]};
    return a;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rom_fill_models();
    for (int i = 0; i < 32; i++) begin
      mem_a[i] = 6'(i) ^ 6'h15;
      mem_b[i] = 6'(i) ^ 6'h15;
    end
  endtask

  // One RUN-mode clock: push expectations from current inputs, update the
  // reference memories for a write, clock, then drain the scoreboard.
  task automatic cyc(input string tag);
    item_t      it;
    logic [5:0] va, vb, obs;
    va = mem_a[map_addr(rd_addr, 1'b1)];
    vb = mem_b[map_addr(rd_addr, 1'b0)];
    if (grey) begin
      va = va & 6'h30;
      vb = vb & 6'h30;
    end
    sb.push_back('{{tag, "_rd_a"}, 2'd0, va});
    sb.push_back('{{tag, "_rd_b"}, 2'd1, vb});
    sb.push_back('{{tag, "_cpu_a"}, 2'd2, mem_a[map_addr(cpu_addr, 1'b1)]});
    sb.push_back('{{tag, "_cpu_b"}, 2'd3, mem_b[map_addr(cpu_addr, 1'b0)]});
    if (cpu_we) begin
      mem_a[map_addr(cpu_addr, 1'b1)] = cpu_wdata;
      mem_b[map_addr(cpu_addr, 1'b0)] = cpu_wdata;
    end
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      case (it.sel)
        2'd0:    obs = rd_data_a;
        2'd1:    obs = rd_data_b;
        2'd2:    obs = cpu_rdata_a;
        default: obs = cpu_rdata_b;
      endcase
      check(it.tag, 32'(obs), 32'(it.exp));
    end
  endtask

  // Count clocks until init_done rises on both instances (bounded).
  task automatic wait_load(input string tag, output int n);
    n = 0;
    while (!(init_done_a && init_done_b) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 3) begin
        init_req = 1'b0;
        cpu_we   = 1'b0;
      end
      if (n < 33) begin
        check({tag, "_ld_rd_a"}, 32'(rd_data_a), 32'h0);
        check({tag, "_ld_done_a"}, 32'(init_done_a), 32'h0);
      end
    end
    check({tag, "_load_clks_a"}, 32'(n), 32'd33);
    check({tag, "_done_b"}, 32'(init_done_b), 32'h1);
  endtask

  logic [5:0] hold_a, hold_b;
  int         n;

  initial begin
    rst       = 1'b1;
    init_req  = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = 5'h00;
    cpu_wdata = 6'h00;
    rd_addr   = 5'h00;
    grey      = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_done", 32'(init_done_a), 32'h0);
    check("rst_ld_addr", 32'(ld_addr_a), 32'h0);
    check("rst_rd_data", 32'(rd_data_a), 32'h0);
    check("rst_cpu_rdata", 32'(cpu_rdata_a), 32'h0);

    // Test 1: initial load, then every entry through the render port.
    rst = 1'b0;
    check("t1_ld_addr0", 32'(ld_addr_a), 32'h0);
    wait_load("t1", n);
    check("t1_ld_addr_run", 32'(ld_addr_a), 32'h0);
    rom_fill_models();
    for (int i = 0; i < 32; i++) begin
      rd_addr  = 5'(i);
      cpu_addr = 5'(31 - i);
      cyc("t1_scan");
    end

    // Test 2: write through the $3F10 alias.
    cpu_we = 1'b1; cpu_addr = 5'h10; cpu_wdata = 6'h2A;
    cyc("t2_wr");
    cpu_we = 1'b0;
    rd_addr = 5'h00; cyc("t2_rd00");
    rd_addr = 5'h10; cyc("t2_rd10");
    check("t2_b_rd10_direct", 32'(rd_data_b), 32'h2A);

    // Test 3: $3F11 is not an alias.
    cpu_we = 1'b1; cpu_addr = 5'h11; cpu_wdata = 6'h07;
    cyc("t3_wr");
    cpu_we = 1'b0;
    rd_addr = 5'h01; cyc("t3_rd01");
    rd_addr = 5'h11; cyc("t3_rd11");

    // Test 4: greyscale masking.
    cpu_we = 1'b1; cpu_addr = 5'h03; cpu_wdata = 6'h27;
    cyc("t4_wr");
    cpu_we = 1'b0;
    rd_addr = 5'h03; grey = 1'b1; cyc("t4_grey");
    check("t4_grey_direct", 32'(rd_data_a), 32'h20);
    grey = 1'b0; cyc("t4_norm");

    // Test 5: same-clock write and read return the old value.
    cpu_we = 1'b1; cpu_addr = 5'h05; cpu_wdata = 6'h38;
    cyc("t5_pre");
    cpu_wdata = 6'h11; rd_addr = 5'h05;
    cyc("t5_rbw");
    check("t5_rbw_direct", 32'(rd_data_a), 32'h38);
    cpu_we = 1'b0;
    cyc("t5_after");

    // Test 6: reload request, writes dropped and cpu_rdata held in LOAD,
    // reset mid-load, init_req during LOAD ignored.
    cpu_addr = 5'h05;
    hold_a   = mem_a[5];
    hold_b   = mem_b[5];
    init_req = 1'b1;
    @(posedge clk);
    #1;
    init_req = 1'b0;
    check("t6_done_low", 32'(init_done_a), 32'h0);
    check("t6_ld_addr0", 32'(ld_addr_a), 32'h0);
    cpu_we = 1'b1; cpu_addr = 5'h00; cpu_wdata = 6'h3F;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      #1;
      check("t6_ld_addr_step", 32'(ld_addr_a), 32'(i));
      check("t6_cpu_hold_a", 32'(cpu_rdata_a), 32'(hold_a));
      check("t6_cpu_hold_b", 32'(cpu_rdata_b), 32'(hold_b));
      check("t6_rd_zero", 32'(rd_data_a), 32'h0);
    end
    rst = 1'b1;
    #2;
    check("t6_rst_ld_addr", 32'(ld_addr_a), 32'h0);
    check("t6_rst_cpu_rdata", 32'(cpu_rdata_a), 32'h0);
    rst      = 1'b0;
    init_req = 1'b1;
    wait_load("t6", n);
    rom_fill_models();
    cpu_we = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rd_addr  = 5'(i);
      cpu_addr = 5'(i);
      cyc("t6_scan");
    end

    // MIRROR_EN=0 instance: write 5'h10 leaves 5'h00 intact.
    cpu_we = 1'b1; cpu_addr = 5'h10; cpu_wdata = 6'h3C;
    cyc("t6_wr10");
    cpu_we = 1'b0;
    rd_addr = 5'h00; cyc("t6_rd00");
    check("t6_b_rd00_direct", 32'(rd_data_b), 32'h15);
    check("t6_a_rd00_direct", 32'(rd_data_a), 32'h3C);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
